// File: rtl/threshold_scan_ctrl.sv
// threshold_scan_ctrl
// Walks a 256-bin intensity histogram from the brightest bin downward in
// CHUNK-bin RAM words. It reports the first bin where the running pixel
// count reaches the programmed target.
// Optional feature macro: THRESHOLD_SCAN_CTRL_ABORT_EN adds an i_abort input.
module threshold_scan_ctrl #(
  parameter int NUM_BINS = 256,
  parameter int BIN_W    = 16,
  parameter int CHUNK    = 8,
  parameter int RD_LAT   = 1,
  parameter int ACC_W    = 24
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_start,
`ifdef THRESHOLD_SCAN_CTRL_ABORT_EN
  input  logic                              i_abort,
`endif
  input  logic [ACC_W-1:0]                  i_target_count,
  output logic                              o_rd_en,
  output logic [$clog2(NUM_BINS/CHUNK)-1:0] o_rd_addr,
  input  logic [CHUNK*BIN_W-1:0]            i_rd_data,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_found,
  output logic [7:0]                        o_threshold,
  output logic [ACC_W-1:0]                  o_cum_count
);

  localparam int NUM_CHUNKS = NUM_BINS / CHUNK;
  localparam int AW         = $clog2(NUM_CHUNKS);
  localparam int LW         = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam int WCW        = $clog2(RD_LAT + 1);
  localparam logic [AW-1:0] TOP_ADDR = AW'(NUM_CHUNKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [ACC_W-1:0]         r_target;
  logic [ACC_W-1:0]         r_acc;
  logic [AW-1:0]            r_addr;
  logic [WCW-1:0]           r_wait_cnt;
  logic [CHUNK*BIN_W-1:0]   r_data;
  logic                     r_found;
  logic [7:0]               r_threshold;
  logic [ACC_W-1:0]         r_cum;

  logic                     w_abort;
  logic                     w_scanning;
  logic                     w_wait_last;
  logic [BIN_W-1:0]         w_lane [CHUNK];
  logic [ACC_W:0]           w_ext;
  logic [ACC_W-1:0]         w_run;
  logic                     w_hit;
  logic [LW-1:0]            w_hit_lane;
  logic [ACC_W-1:0]         w_hit_sum;
  logic [ACC_W-1:0]         w_chunk_sum;

`ifdef THRESHOLD_SCAN_CTRL_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // Abort only has an effect while a scan is actually fetching/evaluating
  assign w_scanning  = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_EVAL);
  assign w_wait_last = (r_wait_cnt == WCW'(RD_LAT - 1));

  // Split the registered RAM word into per-bin lanes
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_lane
    assign w_lane[gi] = r_data[gi*BIN_W +: BIN_W];
  end

  // Saturating prefix sums from the top lane down; remember the first lane reaching target
  always_comb begin
    w_run       = r_acc;
    w_ext       = '0;
    w_hit       = 1'b0;
    w_hit_lane  = '0;
    w_hit_sum   = '0;
    for (int l = CHUNK - 1; l >= 0; l--) begin
      w_ext = {1'b0, w_run} + (ACC_W+1)'(w_lane[l]);
      w_run = w_ext[ACC_W] ? {ACC_W{1'b1}} : w_ext[ACC_W-1:0];
      if (!w_hit && (w_run >= r_target)) begin
        w_hit      = 1'b1;
        w_hit_lane = LW'(l);
        w_hit_sum  = w_run;
      end
    end
    w_chunk_sum = w_run;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_next = (i_target_count == '0) ? S_DONE : S_REQ;
      S_REQ:  w_state_next = w_abort ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (w_abort)          w_state_next = S_DONE;
        else if (w_wait_last) w_state_next = S_EVAL;
      end
      S_EVAL: begin
        if (w_abort || w_hit || (r_addr == '0)) w_state_next = S_DONE;
        else                                    w_state_next = S_REQ;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM-decoded outputs; the address bus is quiet outside the read strobe
  always_comb begin
    o_rd_en   = (r_state == S_REQ);
    o_rd_addr = (r_state == S_REQ) ? r_addr : '0;
    o_busy    = (r_state != S_IDLE);
    o_done    = (r_state == S_DONE);
  end

  // Datapath: target capture, accumulation, read-data capture and result registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_target    <= '0;
      r_acc       <= '0;
      r_addr      <= TOP_ADDR;
      r_wait_cnt  <= '0;
      r_data      <= '0;
      r_found     <= 1'b0;
      r_threshold <= '0;
      r_cum       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_target    <= i_target_count;
            r_acc       <= '0;
            r_addr      <= TOP_ADDR;
            r_wait_cnt  <= '0;
            r_cum       <= '0;
            // A zero target is met before any bin is counted
            r_found     <= (i_target_count == '0);
            r_threshold <= (i_target_count == '0) ? 8'(NUM_BINS - 1) : 8'd0;
          end
        end
        S_REQ: r_wait_cnt <= '0;
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + WCW'(1);
          if (w_wait_last) r_data <= i_rd_data;
        end
        S_EVAL: begin
          if (w_hit) begin
            r_found     <= 1'b1;
            r_threshold <= 8'(r_addr) * 8'(CHUNK) + 8'(w_hit_lane);
            r_cum       <= w_hit_sum;
          end else if (r_addr != '0) begin
            r_acc  <= w_chunk_sum;
            r_addr <= r_addr - AW'(1);
          end else begin
            r_found     <= 1'b0;
            r_threshold <= '0;
            r_cum       <= w_chunk_sum;
          end
        end
        default: ;
      endcase
      // Abort overrides any EVAL outcome in the same cycle
      if (w_abort && w_scanning) begin
        r_found     <= 1'b0;
        r_threshold <= '0;
        r_cum       <= r_acc;
      end
    end
  end

  assign o_found     = r_found;
  assign o_threshold = r_threshold;
  assign o_cum_count = r_cum;

endmodule

// File: tb/tb_threshold_scan_ctrl.sv
// Bench for threshold_scan_ctrl: instance A (RD_LAT=1, ACC_W=24) and
// instance B (RD_LAT=3, ACC_W=20, used for chunk period and saturation).
module tb_threshold_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] hist [256];
  localparam logic [127:0] JUNK = {8{16'hBEEF}};

  // Instance A signals
  logic         start_a = 1'b0;
  logic [23:0]  tgt_a = '0;
  logic         rd_en_a;
  logic [4:0]   addr_a;
  logic [127:0] rdata_a;
  logic         busy_a, done_a, found_a;
  logic [7:0]   thr_a;
  logic [23:0]  cum_a;
  logic         abort_a = 1'b0;

  // Instance B signals
  logic         start_b = 1'b0;
  logic [19:0]  tgt_b = '0;
  logic         rd_en_b;
  logic [4:0]   addr_b;
  logic [127:0] rdata_b;
  logic         busy_b, done_b, found_b;
  logic [7:0]   thr_b;
  logic [19:0]  cum_b;
  logic         abort_b = 1'b0;

  int errors = 0;
  int checks = 0;
  int scan_no = 0;

  typedef struct {
    logic        found;
    logic [7:0]  thr;
    logic [23:0] cum;
    int          cyc;
    int          reads;
  } exp_t;
  exp_t sb[$];

  threshold_scan_ctrl #(.RD_LAT(1), .ACC_W(24)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a),
`ifdef THRESHOLD_SCAN_CTRL_ABORT_EN
    .i_abort(abort_a),
`endif
    .i_target_count(tgt_a), .o_rd_en(rd_en_a), .o_rd_addr(addr_a),
    .i_rd_data(rdata_a), .o_busy(busy_a), .o_done(done_a), .o_found(found_a),
    .o_threshold(thr_a), .o_cum_count(cum_a)
  );

  threshold_scan_ctrl #(.RD_LAT(3), .ACC_W(20)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b),
`ifdef THRESHOLD_SCAN_CTRL_ABORT_EN
    .i_abort(abort_b),
`endif
    .i_target_count(tgt_b), .o_rd_en(rd_en_b), .o_rd_addr(addr_b),
    .i_rd_data(rdata_b), .o_busy(busy_b), .o_done(done_b), .o_found(found_b),
    .o_threshold(thr_b), .o_cum_count(cum_b)
  );

  function automatic logic [127:0] word(input logic [4:0] a);
    logic [127:0] w;
    int idx;
    w = '0;
    for (int l = 0; l < 8; l++) begin
      idx = int'(a) * 8 + l;
      w[l*16 +: 16] = hist[idx];
    end
    return w;
  endfunction

  // RAM models: data is only meaningful exactly RD_LAT cycles after the strobe
  logic         va = 1'b0;
  logic [127:0] pa = '0;
  always @(posedge clk) begin
    va <= rd_en_a;
    pa <= word(addr_a);
  end
  assign rdata_a = va ? pa : JUNK;

  logic         vb0 = 1'b0, vb1 = 1'b0, vb2 = 1'b0;
  logic [127:0] pb0 = '0, pb1 = '0, pb2 = '0;
  always @(posedge clk) begin
    vb0 <= rd_en_b; pb0 <= word(addr_b);
    vb1 <= vb0;     pb1 <= pb0;
    vb2 <= vb1;     pb2 <= pb1;
  end
  assign rdata_b = vb2 ? pb2 : JUNK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 256; i++) hist[i] = v;
  endtask

  // One scan: push expectation, pulse start, watch reads until o_done, pop and compare
  task automatic run_scan(input bit b, input logic [23:0] tgt, input logic f,
                          input logic [7:0] thr, input logic [23:0] cum,
                          input int cyc, input int reads,
                          input int poke_cyc, input int abort_cyc);
    exp_t e;
    int   n;
    int   nr;
    bit   got;
    logic d, re, bz, fo;
    logic [4:0]  ad;
    logic [7:0]  th;
    logic [23:0] cm;
    e.found = f; e.thr = thr; e.cum = cum; e.cyc = cyc; e.reads = reads;
    sb.push_back(e);
    @(negedge clk);
    if (b) begin start_b = 1'b1; tgt_b = tgt[19:0]; end
    else   begin start_a = 1'b1; tgt_a = tgt;       end
    @(posedge clk);
    #1;
    start_a = 1'b0; start_b = 1'b0;
    tgt_a = 24'h1; tgt_b = 20'h1;   // must not be re-sampled mid-scan
    n = 0; nr = 0; got = 1'b0;
    while (n < 2000 && !got) begin
      @(negedge clk);
      n++;
      d  = b ? done_b  : done_a;
      re = b ? rd_en_b : rd_en_a;
      ad = b ? addr_b  : addr_a;
      if (re) begin
        chk("rd_addr", 32'(ad), 32'(31 - nr));
        nr++;
      end
      if (d) got = 1'b1;
      if (b) start_b = (n == poke_cyc) && !d;
      else   start_a = (n == poke_cyc) && !d;
      abort_a = !b && (n == abort_cyc) && !d;
      abort_b =  b && (n == abort_cyc) && !d;
    end
    start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    e  = sb.pop_front();
    bz = b ? busy_b  : busy_a;
    fo = b ? found_b : found_a;
    th = b ? thr_b   : thr_a;
    cm = b ? {4'h0, cum_b} : cum_a;
    chk("busy_at_done", 32'(bz), 32'd1);
    chk("found", 32'(fo), 32'(e.found));
    chk("threshold", 32'(th), 32'(e.thr));
    chk("cum_count", 32'(cm), 32'(e.cum));
    chk("done_cycle", 32'(n), 32'(e.cyc));
    chk("read_count", 32'(nr), 32'(e.reads));
    $display("scan %0d inst=%s tgt=%0h found=%0b thr=%0d cum=%0h cyc=%0d reads=%0d",
             scan_no, b ? "B" : "A", tgt, fo, th, cm, n, nr);
    scan_no++;
    @(negedge clk);
    chk("busy_after", 32'(b ? busy_b : busy_a), 32'd0);
    chk("done_after", 32'(b ? done_b : done_a), 32'd0);
    chk("found_hold", 32'(b ? found_b : found_a), 32'(e.found));
  endtask

  initial begin
    int  n;
    bit  seen;
    fill(16'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_rden_a", 32'(rd_en_a), 0);
    chk("rst_done_a", 32'(done_a), 0);
    chk("rst_found_a", 32'(found_a), 0);
    chk("rst_thr_a", 32'(thr_a), 0);
    chk("rst_cum_a", 32'(cum_a), 0);
    chk("rst_addr_a", 32'(addr_a), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    rst_n = 1'b1;

    // Hit in the top chunk
    fill(16'h0); hist[255] = 16'd3; hist[254] = 16'd4;
    run_scan(0, 24'd5, 1'b1, 8'd254, 24'd7, 4, 1, -1, -1);

    // Zero target: no reads, done next cycle
    run_scan(0, 24'd0, 1'b1, 8'd255, 24'd0, 1, 0, -1, -1);

    // Hit in the last chunk; a start mid-scan is ignored
    fill(16'h0);
    for (int i = 0; i < 8; i++) hist[i] = 16'd20;
    run_scan(0, 24'd100, 1'b1, 8'd3, 24'd100, 97, 32, 10, -1);

    // Never reached
    fill(16'h1);
    run_scan(0, 24'd1000, 1'b0, 8'd0, 24'd256, 97, 32, -1, -1);

    // Exact hit on lane 0 of the top chunk, and first lane of the next chunk
    run_scan(0, 24'd8, 1'b1, 8'd248, 24'd8, 4, 1, -1, -1);
    run_scan(0, 24'd9, 1'b1, 8'd247, 24'd9, 7, 2, -1, -1);

    // Full-scale bins, 24-bit sum stays just below full scale
    fill(16'hFFFF);
    run_scan(0, 24'hFFFFFF, 1'b0, 8'd0, 24'hFFFF00, 97, 32, -1, -1);

    // Instance B: saturating 20-bit sum counts as reaching full-scale target
    run_scan(1, 24'h0FFFFF, 1'b1, 8'd239, 24'h0FFFFF, 16, 3, -1, -1);

    // Instance B: 5-cycle chunk period
    fill(16'h0); hist[255] = 16'd3; hist[254] = 16'd4;
    run_scan(1, 24'd5, 1'b1, 8'd254, 24'd7, 6, 1, -1, -1);

    // Reset during WAIT of chunk 20, then a clean restart
    fill(16'h1);
    @(negedge clk); start_a = 1'b1; tgt_a = 24'd1000;
    @(posedge clk); #1; start_a = 1'b0;
    n = 0; seen = 1'b0;
    while (n < 500 && !seen) begin
      @(negedge clk);
      n++;
      if (rd_en_a && addr_a == 5'd20) seen = 1'b1;
    end
    chk("reach_chunk20", 32'(seen), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy_a), 0);
    chk("mid_rst_rden", 32'(rd_en_a), 0);
    chk("mid_rst_cum", 32'(cum_a), 0);
    rst_n = 1'b1;
    fill(16'h0); hist[255] = 16'd3; hist[254] = 16'd4;
    run_scan(0, 24'd5, 1'b1, 8'd254, 24'd7, 4, 1, -1, -1);

`ifdef THRESHOLD_SCAN_CTRL_ABORT_EN
    // Abort in chunk 30 EVAL wins over the hit there
    fill(16'h1);
    run_scan(0, 24'd9, 1'b0, 8'd0, 24'd8, 7, 2, -1, 6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
